// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: sequences new-game / play / serve / pause / game-over for
// 1..4 players, owning the frame-counted serve timer, BCD scores and balls.
module pong_match_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int BALLS        = 3,
  parameter int WIN_SCORE    = 11,
  parameter int TIMER_FRAMES = 120
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [2*NUM_PLAYERS-1:0] btn,
  input  logic                     pause_req,
  input  logic                     mode,
  input  logic [NUM_PLAYERS-1:0]   hit,
  input  logic [NUM_PLAYERS-1:0]   miss,
  output logic                     gra_still,
  output logic [2:0]               state,
  output logic [3:0]               balls_left,
  output logic [8*NUM_PLAYERS-1:0] score,
  output logic [1:0]               serve_player,
  output logic [1:0]               winner,
  output logic                     show_rules,
  output logic                     show_over,
  output logic                     show_pause
);

  typedef enum logic [2:0] {
    S_NEWGAME = 3'd0,
    S_PLAY    = 3'd1,
    S_NEWBALL = 3'd2,
    S_PAUSE   = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  state_t     state_q, next_state;
  logic [7:0] score_q [NUM_PLAYERS];
  logic [3:0] balls_q;
  logic [1:0] serve_q, winner_q;
  logic [7:0] timer_q;
  logic       mode_q;

  logic       timer_up;
  logic       press_any, hit_any, miss_any;
  logic [1:0] press_idx, hit_idx, miss_idx, next_idx, best_idx;
  logic [7:0] next_score, best_val;
  logic       win_hit;

  // Saturating two-digit BCD increment (99 stays 99)
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign timer_up = (timer_q == 8'd0);

  // Decode player events (lowest index wins), mode-1 scorer and current leader
  always_comb begin
    press_any = 1'b0;
    press_idx = 2'd0;
    hit_any   = 1'b0;
    hit_idx   = 2'd0;
    miss_any  = 1'b0;
    miss_idx  = 2'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (btn[2*i +: 2] != 2'b00) begin
        press_any = 1'b1;
        press_idx = 2'(i);
      end
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = 2'(i);
      end
      if (miss[i]) begin
        miss_any = 1'b1;
        miss_idx = 2'(i);
      end
    end
    if (int'(miss_idx) == NUM_PLAYERS - 1)
      next_idx = 2'd0;
    else
      next_idx = miss_idx + 2'd1;
    next_score = 8'd0;
    best_idx   = 2'd0;
    best_val   = score_q[0];
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (2'(i) == next_idx)
        next_score = bcd_inc(score_q[i]);
      if (score_q[i] > best_val) begin
        best_val = score_q[i];
        best_idx = 2'(i);
      end
    end
    win_hit = (next_score == WIN_BCD);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_NEWGAME;
    else
      state_q <= next_state;
  end

  // Next-state logic; in PLAY a miss beats a hit, which beats a pause request
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_NEWGAME: if (press_any) next_state = S_PLAY;
      S_PLAY: begin
        if (miss_any) begin
          if (!mode_q)
            next_state = (balls_q == 4'd0) ? S_OVER : S_NEWBALL;
          else
            next_state = win_hit ? S_OVER : S_NEWBALL;
        end else if (!hit_any && pause_req) begin
          next_state = S_PAUSE;
        end
      end
      S_NEWBALL: if (timer_up && press_any) next_state = S_PLAY;
      S_PAUSE:   if (pause_req) next_state = S_PLAY;
      S_OVER:    if (timer_up) next_state = S_NEWGAME;
      default:   next_state = S_NEWGAME;
    endcase
  end

  // Timer, scores, ball budget, serve/winner and latched game mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= 8'd0;
      balls_q  <= 4'(BALLS);
      serve_q  <= 2'd0;
      winner_q <= 2'd0;
      timer_q  <= 8'd0;
      mode_q   <= 1'b0;
    end else begin
      if (state_q == S_PLAY && miss_any)
        timer_q <= 8'(TIMER_FRAMES);
      else if (frame_tick && !timer_up && state_q != S_PAUSE)
        timer_q <= timer_q - 8'd1;
      case (state_q)
        S_NEWGAME: begin
          for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= 8'd0;
          balls_q <= 4'(BALLS);
          if (press_any) begin
            mode_q  <= mode;
            serve_q <= press_idx;
            if (!mode) balls_q <= 4'(BALLS - 1);
          end
        end
        S_PLAY: begin
          if (miss_any) begin
            if (!mode_q) begin
              if (balls_q == 4'd0) winner_q <= best_idx;
              else                 balls_q  <= balls_q - 4'd1;
            end else begin
              for (int i = 0; i < NUM_PLAYERS; i++)
                if (2'(i) == next_idx) score_q[i] <= next_score;
              if (win_hit) winner_q <= next_idx;
            end
          end else if (hit_any && !mode_q) begin
            for (int i = 0; i < NUM_PLAYERS; i++)
              if (2'(i) == hit_idx) score_q[i] <= bcd_inc(score_q[i]);
          end
        end
        S_NEWBALL: if (timer_up && press_any) serve_q <= press_idx;
        S_OVER: begin
          if (timer_up) begin
            for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= 8'd0;
            balls_q <= 4'(BALLS);
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs, all taken straight from registers
  always_comb begin
    state        = state_q;
    gra_still    = (state_q != S_PLAY);
    show_rules   = (state_q == S_NEWGAME);
    show_over    = (state_q == S_OVER);
    show_pause   = (state_q == S_PAUSE);
    balls_left   = balls_q;
    serve_player = serve_q;
    winner       = winner_q;
    score        = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) score[8*i +: 8] = score_q[i];
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Parametrised match controller for the Pong display pipeline. It sequences new-game, play, serve, pause and game-over for 1–4 players, and owns the 2-second frame-counted timer, per-player BCD scores and ball budget. It has two scoring modes: ball-count, and first-to-N. It sits between the graphics unit (hit/miss in, freeze out) and the text/RGB mux (scores, balls, overlay selects out), with no video timing of its own beyond a frame tick.

## Interface
- NUM_PLAYERS, 2: number of paddles/players, 1..4.
- BALLS, 3: balls per game in mode 0, 1..15.
- WIN_SCORE, 11: decimal target score in mode 1, 1..99.
- TIMER_FRAMES, 120: frame ticks for the serve/over timer (2 s at 60 Hz), 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- btn  in  2*NUM_PLAYERS  paddle buttons, 2 per player; pair i = btn[2i+1:2i].
- pause_req  in  1  debounced one-cycle pause toggle request.
- mode  in  1  0 = ball-count game, 1 = first to WIN_SCORE.
- hit  in  NUM_PLAYERS  one-cycle pulse, player i returned the ball.
- miss  in  NUM_PLAYERS  one-cycle pulse, player i missed.
- gra_still  out  1  freeze graphics animation.
- state  out  3  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 PAUSE, 4 OVER.
- balls_left  out  4  remaining balls (mode 0).
- score  out  8*NUM_PLAYERS  two BCD digits per player; player i = score[8i+7:8i].
- serve_player  out  2  player who started the current ball.
- winner  out  2  winning player, valid in OVER.
- show_rules, show_over, show_pause  out  1 each  text overlay selects.

## Operation
- Reset: state NEWGAME, scores 0, balls_left = BALLS, serve_player 0, winner 0, timer count 0, mode_q 0.
- Moore outputs:
  - gra_still = 0 only in PLAY.
  - show_rules = NEWGAME, show_over = OVER, show_pause = PAUSE.
- Any press on player i = (btn pair i != 0). When several players press, the lowest index is taken.
- NEWGAME:
  - Scores are held at 0 and balls_left at BALLS.
  - Any press: go to PLAY. mode_q <= mode, serve_player <= pressing player, and balls_left <= BALLS-1 in mode 0.
- PLAY:
  - Events are evaluated in priority order miss > hit > pause_req. Among simultaneous misses, the lowest index is taken; only one event is processed per cycle.
  - Hit i, mode 0: score[i] += 1 (BCD). In mode 1, hits are ignored.
  - Miss i, mode 0:
    - If balls_left == 0: go to OVER, with winner = highest score (lowest index on ties).
    - Otherwise: go to NEWBALL and decrement balls_left.
  - Miss i, mode 1:
    - Player j = (i+1) mod NUM_PLAYERS gains 1; for NUM_PLAYERS = 1, j = 0.
    - If the new score equals WIN_SCORE: go to OVER with winner = j.
    - Otherwise: go to NEWBALL.
  - Every miss loads the timer with TIMER_FRAMES.
  - pause_req alone: go to PAUSE.
- NEWBALL: when timer_up and any press, go to PLAY with serve_player <= pressing player.
- PAUSE:
  - pause_req: go back to PLAY.
  - Timer, scores and balls are frozen.
  - Hit/miss inputs are ignored.
- OVER: when timer_up, go to NEWGAME. Scores are held for display until NEWGAME clears them.
- Mode changes outside NEWGAME have no effect.
- BCD increment:
  - Units 9 -> 0 with a tens carry.
  - Saturates at 99; a further increment is a no-op.
- Timer:
  - 8-bit down-counter; load has priority over decrement.
  - Decrements on frame_tick when the count is nonzero and state != PAUSE.
  - timer_up = (count == 0).

## Timing
- All outputs derive from registers only; no combinational path from any input to any output.
- Every transition and score/balls update is visible one cycle after the qualifying input edge.
- Timer expiry: timer_up rises on the cycle after the TIMER_FRAMES-th frame_tick following the load.
- frame_tick coincident with the load cycle is not counted.
- A press held across NEWBALL entry still advances the FSM as soon as timer_up rises.
- Reset mid-game: returns immediately to reset values, asynchronously.

## Test plan
- Mode 0, BALLS=3, 2 players:
  - btn=01 -> PLAY, balls_left 2, serve 0.
  - 3 hits on player 1 -> score[15:8]=0x03.
  - 3 misses -> OVER, winner 1.
  - 120 frame_ticks -> NEWGAME, scores 0.
- Timer: miss at PLAY -> NEWBALL.
  - btn held: stays through 119 ticks, enters PLAY 1 cycle after the 120th.
  - Tick on the miss cycle is not counted.
- Mode 1, WIN_SCORE=11: 11 misses by player 0 (each re-served) -> score[15:8]=0x11, OVER, winner 1.
- BCD: 99 hits on player 0 -> 0x99; 100th hit -> still 0x99. 0x09 -> 0x10 on one hit.
- Priority:
  - Same-cycle hit[0] + miss[1] + pause_req -> NEWBALL, no score change.
  - pause_req alone -> PAUSE, gra_still=1, timer frozen over 50 ticks.
  - pause_req -> PLAY.
- Reset asserted in NEWBALL with timer at 60 -> NEWGAME, balls_left 3, timer_up=1, all scores 0.
